// File: rtl/f_reg_file_sb_if.sv
// Bus bundle for the FP register file: write port, two read ports, issue/scoreboard signals.
interface f_reg_file_sb_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 17,
    parameter int unsigned SEL_W    = 32
);
    localparam int unsigned ADDR_W = 5;

    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_dest;
    logic [ADDR_W-1:0]   issue_src_a;
    logic [ADDR_W-1:0]   issue_src_b;
    logic                issue_ready_c;
    logic [NUM_REGS-1:0] busy;
    logic                sel_err;

    modport master (
        output wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b,
               issue_valid, issue_dest, issue_src_a, issue_src_b,
        input  rd_data_a, rd_data_b, issue_ready_c, busy, sel_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b,
               issue_valid, issue_dest, issue_src_a, issue_src_b,
        output rd_data_a, rd_data_b, issue_ready_c, busy, sel_err
    );
endinterface

// File: rtl/f_reg_file_sb.sv
// FP register file with one-hot write select, bypassed registered reads and a
// busy-bit scoreboard that gates FP op issue.
module f_reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 17,
    parameter int unsigned SEL_W    = 32
) (
    input logic            clk_i,
    input logic            rst_ni,
    f_reg_file_sb_if.slave bus
);
    localparam int unsigned ADDR_W = 5;
    localparam logic [SEL_W-1:0] SEL_LO_MASK =
        (NUM_REGS >= SEL_W) ? '1 : ((SEL_W'(1) << NUM_REGS) - SEL_W'(1));

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   rd_a_d, rd_a_q;
    logic [DATA_W-1:0]   rd_b_d, rd_b_q;
    logic [NUM_REGS-1:0] busy_d, busy_q;
    logic                sel_err_d, sel_err_q;
    logic                sel_legal;
    logic                wr_legal;
    logic [NUM_REGS-1:0] wr_we;
    logic                ready_c;
    logic                issue_acc;

    function automatic logic busy_at(input logic [ADDR_W-1:0] idx,
                                     input logic [NUM_REGS-1:0] b);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == ADDR_W'(k)) hit = b[k];
        end
        return hit;
    endfunction

    // Exactly one bit set, and that bit inside the implemented register range.
    assign sel_legal = (bus.wr_sel != '0)
                     && ((bus.wr_sel & (bus.wr_sel - SEL_W'(1))) == '0)
                     && ((bus.wr_sel & ~SEL_LO_MASK) == '0);
    assign wr_legal  = bus.wr_en & sel_legal;

    always_comb begin
        wr_we = '0;
        for (int k = 0; k < NUM_REGS; k++) wr_we[k] = wr_legal & bus.wr_sel[k];
    end

    // Read mux with write-through; out-of-range addresses read as zero.
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.rd_addr_a == ADDR_W'(k)) rd_a_d = wr_we[k] ? bus.wr_data : regs_q[k];
            if (bus.rd_addr_b == ADDR_W'(k)) rd_b_d = wr_we[k] ? bus.wr_data : regs_q[k];
        end
    end

    // Readiness looks at current busy bits only; a same-cycle write does not unblock.
    assign ready_c = (32'(bus.issue_dest) < NUM_REGS)
                   & ~busy_at(bus.issue_dest, busy_q)
                   & ~busy_at(bus.issue_src_a, busy_q)
                   & ~busy_at(bus.issue_src_b, busy_q);
    assign issue_acc = bus.issue_valid & ready_c;

    // New producer wins over a completing write to the same register.
    always_comb begin
        busy_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            busy_d[k] = (busy_q[k] & ~wr_we[k])
                      | (issue_acc & (bus.issue_dest == ADDR_W'(k)));
        end
    end

    assign sel_err_d = sel_err_q | (bus.wr_en & ~sel_legal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            busy_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_we[k]) regs_q[k] <= bus.wr_data;
            end
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.rd_data_a     = rd_a_q;
    assign bus.rd_data_b     = rd_b_q;
    assign bus.busy          = busy_q;
    assign bus.sel_err       = sel_err_q;
    assign bus.issue_ready_c = ready_c;
endmodule
